// File: rtl/svcs_hs_frame_rx_pkg.sv
// Shared constants, enums and helpers for the SVCS handshake receive path.
// Covers header word layout, element kinds, receiver FSM states and payload sizing.
package svcs_rtl_pkg;

  localparam int SVCS_MAX_SIZE = 4096;

  // Word positions inside the 7-word transaction header
  localparam int HDR_W_TYPE_LO  = 0;
  localparam int HDR_W_TYPE_HI  = 1;
  localparam int HDR_W_ID_LO    = 2;
  localparam int HDR_W_ID_HI    = 3;
  localparam int HDR_W_DTYPE_LO = 4;
  localparam int HDR_W_DTYPE_HI = 5;
  localparam int HDR_W_NPAY     = 6;
  localparam int HDR_WORDS      = 7;

  typedef enum logic [1:0] {
    EK_BYTE = 2'd0,
    EK_INT  = 2'd1,
    EK_REAL = 2'd2,
    EK_RSVD = 2'd3
  } elem_kind_e;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_HDR_OUT = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_e;

  // Stream words needed to carry n elements of the given kind (34 bits so 2n never overflows)
  function automatic logic [33:0] payload_words(input elem_kind_e kind, input logic [31:0] n);
    logic [33:0] n34;
    n34 = {{2{n[31]}}, n};
    case (kind)
      EK_BYTE: return (n34 + 34'd3) >> 2;
      EK_INT:  return n34;
      EK_REAL: return n34 << 1;
      default: return n34;
    endcase
  endfunction

endpackage

// File: rtl/svcs_hs_frame_rx_if.sv
// Word-stream, header and payload handshake bundle for the SVCS frame receiver.
// The slave modport is the receiver's view; master is the surrounding environment.
interface svcs_hs_frame_rx_if #(
  parameter int DW = 32
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  logic          hdr_valid;
  logic          hdr_ready;
  logic [63:0]   hdr_trnx_type;
  logic [63:0]   hdr_trnx_id;
  logic [63:0]   hdr_data_type;
  logic [31:0]   hdr_n_payloads;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, hdr_ready, m_ready,
    input  s_ready, hdr_valid, hdr_trnx_type, hdr_trnx_id, hdr_data_type,
           hdr_n_payloads, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, hdr_ready, m_ready,
    output s_ready, hdr_valid, hdr_trnx_type, hdr_trnx_id, hdr_data_type,
           hdr_n_payloads, m_valid, m_data, m_last
  );
endinterface

// File: rtl/svcs_hs_frame_rx.sv
// SVCS frame receiver: captures the 7-word header, offers it on a handshake, then
// forwards exactly the implied payload words (or drops a bad frame and pulses err_pulse).
module svcs_hs_frame_rx
  import svcs_rtl_pkg::*;
#(
  parameter int MAX_PAYLOADS = SVCS_MAX_SIZE,
  parameter int DW           = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               cfg_elem_kind,
  svcs_hs_frame_rx_if.slave        bus,
  output logic                     err_pulse,
  output logic [31:0]              frame_cnt
);

  rx_state_e   state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [33:0] cnt_reg, cnt_next;
  elem_kind_e  kind_reg, kind_next;
  logic [31:0] frame_cnt_reg, frame_cnt_next;
  logic [63:0] hdr_type_reg, hdr_id_reg, hdr_dtype_reg;
  logic [31:0] hdr_npay_reg;
  logic        hdr_load;
  logic [DW-1:0] word_in;
  logic        frame_bad;
  logic [32:0] npay_mag;
  logic [33:0] drop_len;

  assign word_in = bus.s_data;

  // Header words 0..5 are buffered; word 6 arrives with the load into the output registers
  genvar gi;
  generate
    for (gi = 0; gi < HDR_W_NPAY; gi++) begin : g_buf
      logic [31:0] word_reg;
      always_ff @(posedge clk) begin
        if (rst)
          word_reg <= '0;
        else if (state_reg == ST_HDR && bus.s_valid && idx_reg == 3'(gi))
          word_reg <= word_in;
      end
    end
  endgenerate

  assign frame_bad = ($signed(hdr_npay_reg) < 0) ||
                     ($signed(hdr_npay_reg) > MAX_PAYLOADS) ||
                     (kind_reg == EK_RSVD);
  assign npay_mag  = hdr_npay_reg[31] ? (33'd0 - {1'b1, hdr_npay_reg}) : {1'b0, hdr_npay_reg};
  assign drop_len  = (npay_mag > 33'(MAX_PAYLOADS)) ? 34'(MAX_PAYLOADS) : {1'b0, npay_mag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HDR;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      kind_reg      <= EK_BYTE;
      frame_cnt_reg <= '0;
      hdr_type_reg  <= '0;
      hdr_id_reg    <= '0;
      hdr_dtype_reg <= '0;
      hdr_npay_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      kind_reg      <= kind_next;
      frame_cnt_reg <= frame_cnt_next;
      if (hdr_load) begin
        hdr_type_reg  <= {g_buf[HDR_W_TYPE_HI].word_reg,  g_buf[HDR_W_TYPE_LO].word_reg};
        hdr_id_reg    <= {g_buf[HDR_W_ID_HI].word_reg,    g_buf[HDR_W_ID_LO].word_reg};
        hdr_dtype_reg <= {g_buf[HDR_W_DTYPE_HI].word_reg, g_buf[HDR_W_DTYPE_LO].word_reg};
        hdr_npay_reg  <= word_in;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    kind_next      = kind_reg;
    frame_cnt_next = frame_cnt_reg;
    hdr_load       = 1'b0;
    bus.s_ready    = 1'b0;
    bus.hdr_valid  = 1'b0;
    bus.m_valid    = 1'b0;
    bus.m_data     = '0;
    bus.m_last     = 1'b0;
    err_pulse      = 1'b0;
    case (state_reg)
      ST_HDR: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          if (idx_reg == 3'(HDR_W_NPAY)) begin
            idx_next   = '0;
            hdr_load   = 1'b1;
            kind_next  = elem_kind_e'(cfg_elem_kind);
            cnt_next   = payload_words(kind_next, word_in);
            state_next = ST_HDR_OUT;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      ST_HDR_OUT: begin
        bus.hdr_valid = 1'b1;
        if (bus.hdr_ready) begin
          if (frame_bad) begin
            state_next = ST_DROP;
            cnt_next   = drop_len;
            err_pulse  = 1'b1;
          end else if (hdr_npay_reg == 32'd0) begin
            state_next     = ST_HDR;
            frame_cnt_next = frame_cnt_reg + 32'd1;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        bus.m_valid = bus.s_valid;
        bus.s_ready = bus.m_ready;
        bus.m_data  = word_in;
        bus.m_last  = (cnt_reg == 34'd1);
        if (bus.s_valid && bus.m_ready) begin
          cnt_next = cnt_reg - 34'd1;
          if (cnt_reg == 34'd1) begin
            state_next     = ST_HDR;
            frame_cnt_next = frame_cnt_reg + 32'd1;
          end
        end
      end
      ST_DROP: begin
        // A zero-length drop (reserved kind with n==0) closes without consuming a word
        bus.s_ready = (cnt_reg != 34'd0);
        if (cnt_reg == 34'd0) begin
          state_next     = ST_HDR;
          frame_cnt_next = frame_cnt_reg + 32'd1;
        end else if (bus.s_valid) begin
          cnt_next = cnt_reg - 34'd1;
          if (cnt_reg == 34'd1) begin
            state_next     = ST_HDR;
            frame_cnt_next = frame_cnt_reg + 32'd1;
          end
        end
      end
      default: state_next = ST_HDR;
    endcase
    // Reset wins over any handshake in the same cycle
    if (rst) begin
      bus.s_ready   = 1'b0;
      bus.hdr_valid = 1'b0;
      bus.m_valid   = 1'b0;
      bus.m_data    = '0;
      bus.m_last    = 1'b0;
      err_pulse     = 1'b0;
    end
  end

  assign bus.hdr_trnx_type  = hdr_type_reg;
  assign bus.hdr_trnx_id    = hdr_id_reg;
  assign bus.hdr_data_type  = hdr_dtype_reg;
  assign bus.hdr_n_payloads = hdr_npay_reg;
  assign frame_cnt          = frame_cnt_reg;

endmodule
